// File: rtl/latency_data_memory_if.sv
// CPU-to-data-memory request/response bundle for the MEM stage.
// The CPU drives the master side and the memory drives the slave side.
interface latency_data_memory_if;
   logic        Read;
   logic        Write;
   logic [31:0] Address;
   logic [31:0] Write_data;
   logic [2:0]  Func3;
   logic [31:0] Read_data;
   logic        busywait;
   logic        Access_error;

   modport master (
      output Read, Write, Address, Write_data, Func3,
      input  Read_data, busywait, Access_error
   );

   modport slave (
      input  Read, Write, Address, Write_data, Func3,
      output Read_data, busywait, Access_error
   );
endinterface

// File: rtl/latency_data_memory.sv
// Multi-cycle word-organised RV32IM data memory with byte/halfword lanes,
// post-reset zeroing sweep and misaligned/unsupported access reporting.
module latency_data_memory #(
   parameter int unsigned DEPTH_WORDS    = 1024,
   parameter int unsigned LATENCY        = 2,
   parameter bit          CLEAR_ON_RESET = 1'b1
) (
   input  logic                   Clock,
   input  logic                   Reset,
   latency_data_memory_if.slave   bus
);

   localparam int unsigned AW = $clog2(DEPTH_WORDS);
   localparam int unsigned CW = (LATENCY <= 2) ? 1 : $clog2(LATENCY);

   typedef enum logic [1:0] {ST_CLEAR, ST_IDLE, ST_WAIT, ST_DONE} state_t;

   state_t          state_q;
   logic [AW-1:0]   sweep_q;
   logic [CW-1:0]   wait_q;
   logic            op_write_q;
   logic [AW-1:0]   idx_q;
   logic [1:0]      lane_q;
   logic [2:0]      f3_q;
   logic [31:0]     wdata_q;
   logic [31:0]     read_data_q;
   logic            err_q;

   logic [31:0]     mem [DEPTH_WORDS];

   logic            req_c;
   logic            both_c;
   logic            commit_c;
   logic            bad_c;
   logic [31:0]     mem_rd_c;
   logic [31:0]     merged_c;
   logic [31:0]     load_c;
   logic [7:0]      byte_c;
   logic [15:0]     half_c;
   logic            mem_we_c;
   logic [AW-1:0]   mem_idx_c;
   logic [31:0]     mem_wdata_c;

   assign req_c    = (state_q == ST_IDLE) && (bus.Read ^ bus.Write);
   assign both_c   = (state_q == ST_IDLE) && bus.Read && bus.Write && !Reset;
   assign commit_c = (state_q == ST_WAIT) && (wait_q == '0);
   assign mem_rd_c = mem[idx_q];

   // Reject reserved encodings, unsigned stores, and accesses not aligned to their size
   always_comb begin
      bad_c = 1'b0;
      case (f3_q)
         3'b011, 3'b110, 3'b111: bad_c = 1'b1;
         3'b100:                 bad_c = op_write_q;
         3'b101:                 bad_c = op_write_q || lane_q[0];
         3'b001:                 bad_c = lane_q[0];
         3'b010:                 bad_c = (lane_q != 2'b00);
         default:                bad_c = 1'b0;
      endcase
   end

   always_comb begin
      merged_c = mem_rd_c;
      case (f3_q[1:0])
         2'b00:   merged_c[{lane_q, 3'b000} +: 8]     = wdata_q[7:0];
         2'b01:   merged_c[{lane_q[1], 4'b0000} +: 16] = wdata_q[15:0];
         default: merged_c = wdata_q;
      endcase
   end

   assign byte_c = mem_rd_c[{lane_q, 3'b000} +: 8];
   assign half_c = mem_rd_c[{lane_q[1], 4'b0000} +: 16];

   always_comb begin
      load_c = mem_rd_c;
      case (f3_q)
         3'b000:  load_c = {{24{byte_c[7]}}, byte_c};
         3'b001:  load_c = {{16{half_c[15]}}, half_c};
         3'b100:  load_c = {24'd0, byte_c};
         3'b101:  load_c = {16'd0, half_c};
         default: load_c = mem_rd_c;
      endcase
   end

   // One write port shared by the zeroing sweep and committed stores
   assign mem_we_c    = !Reset && ((state_q == ST_CLEAR) || (commit_c && op_write_q && !bad_c));
   assign mem_idx_c   = (state_q == ST_CLEAR) ? sweep_q : idx_q;
   assign mem_wdata_c = (state_q == ST_CLEAR) ? 32'd0 : merged_c;

   always_ff @(posedge Clock) begin
      if (mem_we_c) mem[mem_idx_c] <= mem_wdata_c;
   end

   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         state_q     <= CLEAR_ON_RESET ? ST_CLEAR : ST_IDLE;
         sweep_q     <= '0;
         wait_q      <= '0;
         op_write_q  <= 1'b0;
         idx_q       <= '0;
         lane_q      <= '0;
         f3_q        <= '0;
         wdata_q     <= '0;
         read_data_q <= '0;
         err_q       <= 1'b0;
      end else begin
         err_q <= 1'b0;
         case (state_q)
            ST_CLEAR: begin
               if (sweep_q == AW'(DEPTH_WORDS - 1)) begin
                  sweep_q <= '0;
                  state_q <= ST_IDLE;
               end else begin
                  sweep_q <= sweep_q + AW'(1);
               end
            end
            ST_IDLE: begin
               if (req_c) begin
                  op_write_q <= bus.Write;
                  idx_q      <= bus.Address[AW+1:2];
                  lane_q     <= bus.Address[1:0];
                  f3_q       <= bus.Func3;
                  wdata_q    <= bus.Write_data;
                  wait_q     <= CW'(LATENCY - 1);
                  state_q    <= ST_WAIT;
               end
            end
            ST_WAIT: begin
               if (commit_c) begin
                  state_q <= ST_DONE;
                  err_q   <= bad_c;
                  if (!op_write_q) read_data_q <= bad_c ? 32'd0 : load_c;
               end else begin
                  wait_q <= wait_q - CW'(1);
               end
            end
            ST_DONE: state_q <= ST_IDLE;
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign bus.Read_data    = read_data_q;
   assign bus.busywait     = Reset || (state_q == ST_CLEAR) || (state_q == ST_WAIT) || req_c;
   assign bus.Access_error = err_q || both_c;

endmodule
